nf_ahb_router: RTL and testbench
================================

NF_AHB_ROUTER -- requirements
Module: nf_ahb_router

Interface
REQ-001 Reset is asynchronous and active-high; single clock domain.
REQ-002 Parameter slave_c, 4, number of AHB slave ports (1..16).
REQ-003 Parameter slave_base, {0x0000_0000,0x0001_0000,0x0002_0000,0x0003_0000}, per-slave base address.
REQ-004 Parameter slave_mask, all 0xFFFF_0000, per-slave decode mask.
REQ-005 Parameter timeout, 255, maximum data-phase wait cycles (1..65535).
REQ-006 clk  in  1  clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 addr  in  32  core request address.
REQ-009 wd  in  32  core write data.
REQ-010 we  in  1  core write enable.
REQ-011 size  in  2  core access size (0 byte, 1 half, 2 word).
REQ-012 req  in  1  core request.
REQ-013 rd  out  32  read data, registered.
REQ-014 req_ack  out  1  one-cycle completion pulse.
REQ-015 err  out  1  error flag, valid with req_ack.
REQ-016 haddr_s, hwdata_s  out  slave_c x 32  per-slave address and write data.
REQ-017 hwrite_s  out  slave_c x 1; htrans_s  out  slave_c x 2; hsize_s, hburst_s  out  slave_c x 3.
REQ-018 hrdata_s  in  slave_c x 32; hresp_s  in  slave_c x 2; hready_s  in  slave_c x 1.
REQ-019 hsel_s  out  slave_c  one-hot slave select.

Function
REQ-020 FSM states: IDLE, ADDR, DATA, RESP.
- IDLE->ADDR: req=1, req_ack=0, aligned, address decoded.
- IDLE->RESP: error, no bus access.
REQ-021 Decode: slave i matches when (addr & slave_mask[i]) == slave_base[i]; lowest index wins on multiple match.
- No match, halfword with addr[0]=1, or word with addr[1:0]!=0: IDLE->RESP with err=1, rd=0, no hsel asserted.
REQ-022 ADDR (one cycle):
- selected hsel_s=1, htrans_s=NONSEQ (2'b10), hburst_s=SINGLE (3'b000), hsize_s={1'b0,size}, haddr_s=addr, hwrite_s=we.
- Unselected ports: htrans IDLE, hsel 0.
REQ-023 DATA:
- htrans_s=IDLE; hwdata_s=wd held stable.
- Wait for selected hready_s=1, then capture hrdata_s into rd, latch err=(hresp_s==ERROR 2'b01), go to RESP.
REQ-024 RESP: req_ack=1 for exactly one cycle, then IDLE; req ignored while req_ack=1.
REQ-025 Latency: req sampled at cycle 0, req_ack at cycle 3 when hready=1 on first DATA cycle; each low-hready cycle adds one.
REQ-026 rd holds its value until the next completed read; writes leave rd unchanged.
REQ-027 Core holds addr/wd/we/size/req stable until req_ack.

Reset
REQ-028 On reset: FSM IDLE; rd=0, req_ack=0, err=0, all hsel_s/htrans_s/hwrite_s=0, haddr_s/hwdata_s=0, hsize_s=0, hburst_s=0, timeout counter=0.
REQ-029 Reset mid-transfer: in-flight transfer discarded, no req_ack produced.

Configuration
REQ-030 Macro NF_AHB_TIMEOUT_EN.
- Defined: DATA-state counter; after timeout consecutive cycles with hready low, go to RESP with err=1, rd unchanged.
- Undefined: no counter; DATA waits indefinitely.

Structure
REQ-031 Package nf_ahb_pkg: HTRANS/HSIZE/HBURST/HRESP constants, router state enum, default slave_base/slave_mask constants.
REQ-032 Sub-module nf_ahb_dec: combinational decoder (addr, size -> one-hot select, decode error).

Verification
REQ-033 Word write 0x0001_0004, data 0xA5A5_A5A5, hready_s[1]=1: hsel_s=0010, htrans NONSEQ one cycle, hwdata 0xA5A5_A5A5 in DATA, req_ack at cycle 3, err=0.
REQ-034 Word read 0x0000_0010, slave 0 returns 0x1234_5678 after 3 wait cycles: req_ack at cycle 6, rd=0x1234_5678.
REQ-035 Read 0x0009_0000 (unmapped): no hsel, req_ack cycle 1 after IDLE, err=1, rd=0.
REQ-036 Halfword write 0x0002_0001: err=1, no bus activity; slave 3 hresp=ERROR on a write: err=1.
REQ-037 NF_AHB_TIMEOUT_EN, timeout=4, hready_s[0] held 0: req_ack with err=1 after 4 DATA cycles; without the macro, req_ack never asserts.
REQ-038 Assert reset during DATA: all outputs return to 0 immediately; no req_ack; the next request completes normally.

Source files
------------

// File: rtl/nf_ahb_pkg.sv
// Shared AHB constants, router FSM states and default slave address map.
package nf_ahb_pkg;

  localparam int unsigned SlaveMax = 16;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  localparam logic [2:0] HsizeByte = 3'b000;
  localparam logic [2:0] HsizeHalf = 3'b001;
  localparam logic [2:0] HsizeWord = 3'b010;

  localparam logic [2:0] HburstSingle = 3'b000;

  localparam logic [1:0] HrespOkay  = 2'b00;
  localparam logic [1:0] HrespError = 2'b01;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  // Slave i lives at i * 64 KiB; only the first slave_c entries are used.
  localparam logic [SlaveMax-1:0][31:0] DefaultBase = {
    32'h000F_0000, 32'h000E_0000, 32'h000D_0000, 32'h000C_0000,
    32'h000B_0000, 32'h000A_0000, 32'h0009_0000, 32'h0008_0000,
    32'h0007_0000, 32'h0006_0000, 32'h0005_0000, 32'h0004_0000,
    32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000
  };

  localparam logic [SlaveMax-1:0][31:0] DefaultMask = {SlaveMax{32'hFFFF_0000}};

endpackage

// File: rtl/nf_ahb_router_if.sv
// Core request port plus per-slave AHB signals of the router.
interface nf_ahb_router_if #(
  parameter int unsigned slave_c = 4
);
  logic [31:0] addr;
  logic [31:0] wd;
  logic        we;
  logic [1:0]  size;
  logic        req;
  logic [31:0] rd;
  logic        req_ack;
  logic        err;

  logic [slave_c-1:0][31:0] haddr_s;
  logic [slave_c-1:0][31:0] hwdata_s;
  logic [slave_c-1:0]       hwrite_s;
  logic [slave_c-1:0][1:0]  htrans_s;
  logic [slave_c-1:0][2:0]  hsize_s;
  logic [slave_c-1:0][2:0]  hburst_s;
  logic [slave_c-1:0]       hsel_s;
  logic [slave_c-1:0][31:0] hrdata_s;
  logic [slave_c-1:0][1:0]  hresp_s;
  logic [slave_c-1:0]       hready_s;

  // Router side: takes core requests, drives the slave buses.
  modport master (
    input  addr, wd, we, size, req, hrdata_s, hresp_s, hready_s,
    output rd, req_ack, err, haddr_s, hwdata_s, hwrite_s, htrans_s, hsize_s, hburst_s, hsel_s
  );

  // Environment side: the core and the slaves together.
  modport slave (
    output addr, wd, we, size, req, hrdata_s, hresp_s, hready_s,
    input  rd, req_ack, err, haddr_s, hwdata_s, hwrite_s, htrans_s, hsize_s, hburst_s, hsel_s
  );
endinterface

// File: rtl/nf_ahb_dec.sv
// Address decoder: one-hot slave select plus decode/alignment error.
module nf_ahb_dec
  import nf_ahb_pkg::*;
#(
  parameter int unsigned                slave_c    = 4,
  parameter logic [SlaveMax-1:0][31:0]  slave_base = DefaultBase,
  parameter logic [SlaveMax-1:0][31:0]  slave_mask = DefaultMask
) (
  input  logic [31:0]        addr,
  input  logic [1:0]         size,
  output logic [slave_c-1:0] sel,
  output logic               dec_err
);

  logic hit;
  logic misalign;

  // Lowest matching index wins.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < slave_c; i++) begin
      if (!hit && ((addr & slave_mask[i]) == slave_base[i])) begin
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

  always_comb begin
    misalign = 1'b1;
    case ({1'b0, size})
      HsizeByte: misalign = 1'b0;
      HsizeHalf: misalign = addr[0];
      HsizeWord: misalign = (addr[1:0] != 2'b00);
      default:   misalign = 1'b1;
    endcase
  end

  assign dec_err = !hit || misalign;

endmodule

// File: rtl/nf_ahb_router.sv
// Single-transfer AHB router: core request -> one selected slave, one-cycle ack.
// Optional data-phase watchdog enabled by defining NF_AHB_TIMEOUT_EN.
module nf_ahb_router
  import nf_ahb_pkg::*;
#(
  parameter int unsigned               slave_c    = 4,
  parameter logic [SlaveMax-1:0][31:0] slave_base = DefaultBase,
  parameter logic [SlaveMax-1:0][31:0] slave_mask = DefaultMask,
  parameter int unsigned               timeout    = 255
) (
  input logic             clk,
  input logic             reset,
  nf_ahb_router_if.master bus
);

  state_e             state;
  logic [slave_c-1:0] dec_sel;
  logic               dec_err;
  logic               hready_sel;
  logic [1:0]         hresp_sel;
  logic [31:0]        hrdata_sel;

  nf_ahb_dec #(
    .slave_c    (slave_c),
    .slave_base (slave_base),
    .slave_mask (slave_mask)
  ) u_dec (
    .addr    (bus.addr),
    .size    (bus.size),
    .sel     (dec_sel),
    .dec_err (dec_err)
  );

  // hsel_s stays asserted through the data phase and steers the response mux.
  always_comb begin
    hready_sel = |(bus.hready_s & bus.hsel_s);
    hresp_sel  = '0;
    hrdata_sel = '0;
    for (int i = 0; i < slave_c; i++) begin
      if (bus.hsel_s[i]) begin
        hresp_sel  = hresp_sel | bus.hresp_s[i];
        hrdata_sel = hrdata_sel | bus.hrdata_s[i];
      end
    end
  end

`ifdef NF_AHB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_hit;
  assign tmo_hit = (tmo_cnt == 16'(timeout - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^16'(timeout);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      bus.rd       <= '0;
      bus.req_ack  <= 1'b0;
      bus.err      <= 1'b0;
      bus.hsel_s   <= '0;
      bus.htrans_s <= '0;
      bus.hwrite_s <= '0;
      bus.haddr_s  <= '0;
      bus.hwdata_s <= '0;
      bus.hsize_s  <= '0;
      bus.hburst_s <= '0;
`ifdef NF_AHB_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.req && !bus.req_ack) begin
            if (dec_err) begin
              state       <= StResp;
              bus.req_ack <= 1'b1;
              bus.err     <= 1'b1;
              bus.rd      <= '0;
            end else begin
              state      <= StAddr;
              bus.hsel_s <= dec_sel;
              for (int i = 0; i < slave_c; i++) begin
                bus.htrans_s[i] <= dec_sel[i] ? HtransNonseq : HtransIdle;
                if (dec_sel[i]) begin
                  bus.haddr_s[i]  <= bus.addr;
                  bus.hwrite_s[i] <= bus.we;
                  bus.hsize_s[i]  <= {1'b0, bus.size};
                  bus.hburst_s[i] <= HburstSingle;
                end
              end
            end
          end
        end
        StAddr: begin
          state        <= StData;
          bus.htrans_s <= '0;
          for (int i = 0; i < slave_c; i++) begin
            if (bus.hsel_s[i]) bus.hwdata_s[i] <= bus.wd;
          end
`ifdef NF_AHB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        StData: begin
          if (hready_sel) begin
            if (!bus.we) bus.rd <= hrdata_sel;
            bus.err     <= (hresp_sel == HrespError);
            bus.req_ack <= 1'b1;
            bus.hsel_s  <= '0;
            state       <= StResp;
`ifdef NF_AHB_TIMEOUT_EN
          end else if (tmo_hit) begin
            bus.err     <= 1'b1;
            bus.req_ack <= 1'b1;
            bus.hsel_s  <= '0;
            state       <= StResp;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
`endif
          end
        end
        StResp: begin
          bus.req_ack <= 1'b0;
          state       <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nf_ahb_router.sv
// Randomised bench for nf_ahb_router against a transaction-level model.
// Handles builds with and without NF_AHB_TIMEOUT_EN.
module tb_nf_ahb_router;

  localparam int unsigned SlaveC  = 4;
  localparam int unsigned Timeout = 4;
  localparam int          Never   = 32'h7fff_ffff;
`ifdef NF_AHB_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;

  nf_ahb_router_if #(.slave_c(SlaveC)) bus ();

  nf_ahb_router #(
    .slave_c (SlaveC),
    .timeout (Timeout)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected transaction, published by the driver for the compare process.
  logic        txn_active;
  int          t0;
  int          exp_done;
  int          tgt;
  logic        exp_derr;
  logic        exp_err;
  logic        exp_we;
  logic [31:0] exp_addr;
  logic [31:0] exp_wd;
  logic [1:0]  exp_sz;
  logic        exp_rd_upd;
  logic [31:0] exp_rd_new;
  logic [31:0] mdl_rd;

  // Observations for the directed literal checks.
  int          ack_count;
  int          last_lat;
  logic        last_err;
  logic [31:0] adr_hsel;

  logic        ack_exp;
  logic        addr_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rd"}, bus.rd, 32'h0);
    check({tag, "_ack"}, 32'(bus.req_ack), 32'h0);
    check({tag, "_err"}, 32'(bus.err), 32'h0);
    check({tag, "_hsel"}, 32'(bus.hsel_s), 32'h0);
    check({tag, "_htrans"}, 32'(|bus.htrans_s), 32'h0);
    check({tag, "_hwrite"}, 32'(|bus.hwrite_s), 32'h0);
    check({tag, "_haddr"}, 32'(|bus.haddr_s), 32'h0);
    check({tag, "_hwdata"}, 32'(|bus.hwdata_s), 32'h0);
    check({tag, "_hsize"}, 32'(|bus.hsize_s), 32'h0);
    check({tag, "_hburst"}, 32'(|bus.hburst_s), 32'h0);
  endtask

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (reset) begin
      mdl_rd = '0;
      check_reset_state("rst");
    end else begin
      ack_exp  = txn_active && (cyc == exp_done);
      addr_cyc = txn_active && !exp_derr && (cyc == t0 + 1);
      check("req_ack", 32'(bus.req_ack), 32'(ack_exp));
      if (bus.req_ack) begin
        ack_count++;
        last_lat = cyc - t0;
        last_err = bus.err;
      end
      if (ack_exp) begin
        check("err", 32'(bus.err), 32'(exp_err));
        if (exp_rd_upd) mdl_rd = exp_rd_new;
      end
      check("rd", bus.rd, mdl_rd);
      for (int i = 0; i < SlaveC; i++) begin
        check("htrans", 32'(bus.htrans_s[i]), (addr_cyc && i == tgt) ? 32'h2 : 32'h0);
      end
      if (txn_active && cyc == t0 + 1) adr_hsel = 32'(bus.hsel_s);
      if (addr_cyc) begin
        check("hsel_addr", 32'(bus.hsel_s), 32'(1) << tgt);
        check("haddr", bus.haddr_s[tgt], exp_addr);
        check("hwrite", 32'(bus.hwrite_s[tgt]), 32'(exp_we));
        check("hsize", 32'(bus.hsize_s[tgt]), 32'(exp_sz));
        check("hburst", 32'(bus.hburst_s[tgt]), 32'h0);
      end else if (!txn_active || cyc <= t0 || cyc >= exp_done) begin
        check("hsel_idle", 32'(bus.hsel_s), 32'h0);
      end
      if (txn_active && !exp_derr && exp_we && cyc >= t0 + 2 && cyc < exp_done) begin
        check("hwdata", bus.hwdata_s[tgt], exp_wd);
      end
    end
  end

  // One core request; the target slave inserts `waits` low-hready cycles after
  // it sees its address phase. abort_at >= 0 pulses reset that many cycles in.
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [1:0] sz,
                         input logic [31:0] d, input int waits, input logic rerr,
                         input logic [31:0] rdata, input int abort_at);
    int   region;
    int   dstart;
    int   bound;
    int   acks0;
    logic misal;
    logic got;
    logic aborted;

    region = int'(a[31:16]);
    misal  = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) || (sz == 2'd3);

    @(posedge clk); #1;
    t0         = cyc;
    exp_derr   = (region >= SlaveC) || misal;
    tgt        = exp_derr ? 0 : region;
    exp_we     = w;
    exp_addr   = a;
    exp_wd     = d;
    exp_sz     = sz;
    exp_rd_upd = 1'b0;
    exp_rd_new = '0;
    if (exp_derr) begin
      exp_done   = t0 + 1;
      exp_err    = 1'b1;
      exp_rd_upd = 1'b1;
    end else if (TmoEn && waits >= Timeout) begin
      exp_done = t0 + 2 + Timeout;
      exp_err  = 1'b1;
    end else if (waits >= 1000) begin
      exp_done = Never;
      exp_err  = 1'b0;
    end else begin
      exp_done   = t0 + 3 + waits;
      exp_err    = rerr;
      exp_rd_upd = !w;
      exp_rd_new = rdata;
    end
    bus.addr   = a;
    bus.wd     = d;
    bus.we     = w;
    bus.size   = sz;
    bus.req    = 1'b1;
    txn_active = 1'b1;
    acks0      = ack_count;
    dstart     = -1;
    aborted    = 1'b0;
    bound      = (waits > 20) ? 30 : waits + 20;

    for (int n = 0; n < bound; n++) begin
      if (n == abort_at) begin
        reset      = 1'b1;
        txn_active = 1'b0;
        aborted    = 1'b1;
        #1;
        check_reset_state("abort");
        break;
      end
      for (int i = 0; i < SlaveC; i++) begin
        bus.hready_s[i] = 1'($urandom);
        bus.hresp_s[i]  = {1'b0, 1'($urandom)};
        bus.hrdata_s[i] = $urandom;
      end
      if (!exp_derr) begin
        bus.hready_s[tgt] = (dstart >= 0) && (cyc - dstart >= waits);
        bus.hresp_s[tgt]  = (bus.hready_s[tgt] && rerr) ? 2'b01 : 2'b00;
        bus.hrdata_s[tgt] = rdata;
      end
      @(negedge clk);
      if (!exp_derr && bus.hsel_s[tgt] && bus.htrans_s[tgt] == 2'b10) dstart = cyc + 1;
      got = bus.req_ack;
      @(posedge clk); #1;
      if (got) break;
    end

    bus.req    = 1'b0;
    txn_active = 1'b0;
    if (aborted) begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort_noack", 32'(ack_count - acks0), 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          rsel;

    n_checks   = 0;
    n_fail     = 0;
    cyc        = 0;
    ack_count  = 0;
    last_lat   = 0;
    last_err   = 1'b0;
    adr_hsel   = '0;
    mdl_rd     = '0;
    txn_active = 1'b0;
    t0         = 0;
    exp_done   = Never;
    tgt        = 0;
    exp_derr   = 1'b0;
    reset      = 1'b1;
    bus.addr   = '0;
    bus.wd     = '0;
    bus.we     = 1'b0;
    bus.size   = '0;
    bus.req    = 1'b0;
    bus.hready_s = '1;
    bus.hresp_s  = '0;
    bus.hrdata_s = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Word write to slave 1, zero wait.
    run_txn(32'h0001_0004, 1'b1, 2'd2, 32'hA5A5_A5A5, 0, 1'b0, 32'h0, -1);
    check("w1_lat", 32'(last_lat), 32'd3);
    check("w1_err", 32'(last_err), 32'd0);
    check("w1_hsel", adr_hsel, 32'b0010);
    check("w1_rd", bus.rd, 32'h0);

    // Word read from slave 0 with three wait states.
    run_txn(32'h0000_0010, 1'b0, 2'd2, 32'h0, 3, 1'b0, 32'h1234_5678, -1);
    check("r0_lat", 32'(last_lat), 32'd6);
    check("r0_rd", bus.rd, 32'h1234_5678);

    // Unmapped read.
    run_txn(32'h0009_0000, 1'b0, 2'd2, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, -1);
    check("um_lat", 32'(last_lat), 32'd1);
    check("um_err", 32'(last_err), 32'd1);
    check("um_rd", bus.rd, 32'h0);
    check("um_hsel", adr_hsel, 32'h0);

    // Misaligned halfword write, then a slave error response on a write.
    run_txn(32'h0002_0001, 1'b1, 2'd1, 32'h1111_2222, 0, 1'b0, 32'h0, -1);
    check("mh_lat", 32'(last_lat), 32'd1);
    check("mh_err", 32'(last_err), 32'd1);
    run_txn(32'h0003_0008, 1'b1, 2'd2, 32'h3333_4444, 0, 1'b1, 32'h0, -1);
    check("se_lat", 32'(last_lat), 32'd3);
    check("se_err", 32'(last_err), 32'd1);

    // Slave 0 never ready: watchdog ends it, or reset has to rescue it.
    rsel = ack_count;
    run_txn(32'h0000_0020, 1'b0, 2'd2, 32'h0, 1000, 1'b0, 32'h5555_AAAA, 25);
`ifdef NF_AHB_TIMEOUT_EN
    check("tmo_lat", 32'(last_lat), 32'd6);
    check("tmo_err", 32'(last_err), 32'd1);
`else
    check("tmo_noack", 32'(ack_count - rsel), 32'd0);
`endif

    // Reset during the data phase, then a normal read.
    run_txn(32'h0002_0040, 1'b0, 2'd2, 32'h0, 8, 1'b0, 32'h7777_7777, 4);
    run_txn(32'h0001_0100, 1'b0, 2'd2, 32'h0, 1, 1'b0, 32'hCAFE_F00D, -1);
    check("post_rst_lat", 32'(last_lat), 32'd4);
    check("post_rst_rd", bus.rd, 32'hCAFE_F00D);

    for (int k = 0; k < 80; k++) begin
      sz = 2'($urandom_range(0, 2));
      a  = {16'($urandom_range(0, 5)), 16'($urandom)};
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      run_txn(a, 1'($urandom), sz, $urandom, int'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0), $urandom, -1);
    end

    @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
